spi_cmd_ctrl: RTL and testbench
===============================

# spi_cmd_ctrl

Command controller sitting directly downstream of the 64-bit SPI word receiver and feeding that same receiver's transmit word. It turns each received 64-bit word into a host command: register write, register read, engine start, status read or error clear. It owns the host-visible register bank and the start/done handshake to the compute engine. The response to each command is presented on `tx_word` for the host to clock out during its next 64-bit transfer.

## Interface
Parameters:
- `NREGS`, default 8: number of 32-bit registers; power of two, 2..256. Register `NREGS-1` is the result register.

Ports:
- `clk` in 1: clock.
- `resetn` in 1: reset, synchronous, active-low.
- `rx_word_valid` in 1: word-received level from the SPI word receiver. Only its rising edge marks a new word.
- `rx_word` in 64: received word; stable while `rx_word_valid` is high.
- `tx_word` out 64: response word, to the receiver's send-data input.
- `regs_flat` out NREGS*32: register bank; reg i occupies bits [32i+31:32i].
- `start` out 1: one-cycle engine start pulse.
- `busy` in 1: engine busy.
- `done` in 1: one-cycle engine completion pulse.
- `result` in 32: engine result, valid while `done`=1.
- `err` out 1: OR of the sticky error bits.

## Operation
- Command fields:
  - [63:56] opcode
  - [55:48] addr
  - [31:0] data
  - [47:32] ignored
- Opcodes:
  - 0x01 WRITE: reg[addr] <= data.
  - 0x02 READ: response data = reg[addr].
  - 0x03 START: if `busy` or `active`, set err_busy and do not pulse. Otherwise pulse `start`, set `active`, clear `rvalid`.
  - 0x04 STATUS: response data = reg[NREGS-1].
  - 0x05 CLEAR: clear all sticky error bits.
  - Any other opcode: set err_op; no other effect.
- Address check (WRITE/READ only): addr >= NREGS sets err_addr. No write occurs and response data = 0.
- Status byte: bit0 `active`, bit1 `rvalid` (sticky), bit2 err_op, bit3 err_addr, bit4 err_busy, bits7:5 = 0.
- `done`: reg[NREGS-1] <= result, `active` <= 0, `rvalid` <= 1. This happens in any FSM state.
- `cmd_count`: 8-bit count of executed commands, incremented on every EXEC including errored ones; wraps 255->0.
- Response word, loaded in EXEC:
  - [63:56] opcode
  - [55:48] addr
  - [47:40] status after this command's effects
  - [39:32] `cmd_count` after increment
  - [31:0] data. WRITE echoes the written value; START and CLEAR give 0; invalid opcodes give 0.
- FSM states:
  - IDLE: on a `rx_word_valid` rising edge, latch `rx_word` into cmd, go to EXEC.
  - EXEC: perform the command, load `tx_word`, return to IDLE.
- Edge detector: previous-value register, reset to 0. A valid level already high when reset releases is not a new word.

## Timing
- Reset values: `tx_word`=0, all regs 0, `start`=0, `err`=0, `active`=0, `rvalid`=0, `cmd_count`=0, FSM in IDLE, edge register 0.
- Cycle E: rising edge of `rx_word_valid` is visible (valid=1, prev=0).
- Edge closing E: cmd latched.
- Edge closing E+1 (EXEC):
  - register write happens;
  - `tx_word` updates;
  - `start`=1 during cycle E+2 only.
- `err` is combinational from the sticky bits, so it is visible in the cycle after EXEC.
- Throughput: one command per 2 cycles. The SPI transfer is much slower, so no input queue is required. An edge arriving while in EXEC is still captured on return to IDLE because the level stays high and the edge register flags the edge.
- Simultaneous `done` and WRITE to reg NREGS-1: `done` wins.
- Simultaneous `done` and START: `done` is applied first, so `active` clears and START succeeds.
- Simultaneous `done` and READ/STATUS of reg NREGS-1: response returns the new `result`.
- `done` while `active`=0: still updates the result register and sets `rvalid`.
- Reset mid-EXEC: command discarded; all outputs return to reset values on the next edge.

## Test plan
- Reset, then WRITE 0x01_03_0000_DEADBEEF -> `regs_flat`[127:96]=0xDEADBEEF two cycles after edge; `tx_word`=0x01_03_00_01_DEADBEEF.
- READ 0x02_03 after the above -> `tx_word`[31:0]=0xDEADBEEF, `cmd_count`=2. READ addr 0x09 with NREGS=8 -> data 0, status bit3=1, `err`=1. CLEAR -> `err`=0, status 0.
- START with `busy`=0 -> `start` high exactly 1 cycle, status=0x01. Second START before `done` -> no pulse, status=0x11. `done` with result 0x12345678, then STATUS -> data 0x12345678, status bit1=1, bit0=0.
- Opcode 0x7F -> status bit2 set, regs unchanged, `cmd_count` still increments. 256 commands -> `cmd_count` wraps to 0.
- `done` in the same cycle as EXEC of WRITE to reg 7 -> reg 7 = `result`. `done` together with START -> START accepted.
- Hold `rx_word_valid` high across reset release -> no command executed. Assert reset during EXEC -> `tx_word`=0 and `start` stays 0.

Source files
------------

// File: rtl/spi_cmd_ctrl.sv
// Host command controller behind the 64-bit SPI word receiver: decodes each word,
// owns the register bank and engine start/done handshake, and builds the response word.
module spi_cmd_ctrl #(
    parameter int NREGS = 8
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  rx_word_valid,
    input  logic [63:0]           rx_word,
    output logic [63:0]           tx_word,
    output logic [NREGS*32-1:0]   regs_flat,
    output logic                  start,
    input  logic                  busy,
    input  logic                  done,
    input  logic [31:0]           result,
    output logic                  err
);
    localparam int AW = $clog2(NREGS);

    typedef enum logic {IDLE, EXEC} state_t;

    state_t                   state, state_n;
    logic [NREGS-1:0][31:0]   regs;
    logic [63:0]              cmd;
    logic                     valid_q, armed;
    logic                     active, rvalid, err_op, err_addr, err_busy;
    logic [7:0]               cmd_count;

    logic                     n_active, n_rvalid, n_err_op, n_err_addr, n_err_busy;
    logic [7:0]               n_count;
    logic                     wr_en, start_n;
    logic [31:0]              rsp_data;
    logic [7:0]               status_n;

    logic [7:0]               op, addr;
    logic [31:0]              data;
    logic [AW-1:0]            idx;
    logic                     addr_ok, is_last, edge_det;
    logic [31:0]              last_eff;

    assign op        = cmd[63:56];
    assign addr      = cmd[55:48];
    assign data      = cmd[31:0];
    assign idx       = addr[AW-1:0];
    assign addr_ok   = ({1'b0, addr} < 9'(NREGS));
    assign is_last   = addr_ok && (idx == AW'(NREGS - 1));
    // A completing engine result is visible to a command executing in the same cycle.
    assign last_eff  = done ? result : regs[NREGS-1];
    // armed blocks a level that was already high across reset release.
    assign edge_det  = armed && rx_word_valid && !valid_q;
    assign regs_flat = regs;
    assign err       = err_op | err_addr | err_busy;

    always_comb begin
        state_n    = state;
        n_active   = done ? 1'b0 : active;
        n_rvalid   = done ? 1'b1 : rvalid;
        n_err_op   = err_op;
        n_err_addr = err_addr;
        n_err_busy = err_busy;
        n_count    = cmd_count;
        wr_en      = 1'b0;
        start_n    = 1'b0;
        rsp_data   = 32'd0;
        case (state)
            IDLE: if (edge_det) state_n = EXEC;
            EXEC: begin
                state_n = IDLE;
                n_count = cmd_count + 8'd1;
                case (op)
                    8'h01: begin
                        if (addr_ok) begin
                            wr_en    = !(done && is_last);
                            rsp_data = data;
                        end else begin
                            n_err_addr = 1'b1;
                        end
                    end
                    8'h02: begin
                        if (addr_ok) rsp_data = is_last ? last_eff : regs[idx];
                        else         n_err_addr = 1'b1;
                    end
                    8'h03: begin
                        if (busy || n_active) begin
                            n_err_busy = 1'b1;
                        end else begin
                            start_n  = 1'b1;
                            n_active = 1'b1;
                            n_rvalid = 1'b0;
                        end
                    end
                    8'h04: rsp_data = last_eff;
                    8'h05: begin
                        n_err_op   = 1'b0;
                        n_err_addr = 1'b0;
                        n_err_busy = 1'b0;
                    end
                    default: n_err_op = 1'b1;
                endcase
            end
            default: state_n = IDLE;
        endcase
        status_n = {3'b000, n_err_busy, n_err_addr, n_err_op, n_rvalid, n_active};
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= IDLE;
            regs      <= '0;
            cmd       <= '0;
            valid_q   <= 1'b0;
            armed     <= 1'b0;
            active    <= 1'b0;
            rvalid    <= 1'b0;
            err_op    <= 1'b0;
            err_addr  <= 1'b0;
            err_busy  <= 1'b0;
            cmd_count <= 8'd0;
            tx_word   <= '0;
            start     <= 1'b0;
        end else begin
            state     <= state_n;
            armed     <= 1'b1;
            // Previous value frozen during EXEC so an edge landing there is seen back in IDLE.
            if (state == IDLE) valid_q <= rx_word_valid;
            if (state == IDLE && edge_det) cmd <= rx_word;
            active    <= n_active;
            rvalid    <= n_rvalid;
            err_op    <= n_err_op;
            err_addr  <= n_err_addr;
            err_busy  <= n_err_busy;
            cmd_count <= n_count;
            start     <= start_n;
            if (state == EXEC) tx_word <= {op, addr, status_n, n_count, rsp_data};
            if (done)  regs[NREGS-1] <= result;
            if (wr_en) regs[idx]     <= data;
        end
    end
endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// Directed bench for spi_cmd_ctrl: a command-level model predicts every output,
// checked each cycle, plus hand-computed response words.
module tb_spi_cmd_ctrl;
    localparam int NREGS = 8;

    logic                 clk, resetn, rx_word_valid, busy, done;
    logic [63:0]          rx_word, tx_word;
    logic [NREGS*32-1:0]  regs_flat;
    logic                 start, err;
    logic [31:0]          result;

    spi_cmd_ctrl #(.NREGS(NREGS)) dut (
        .clk(clk), .resetn(resetn), .rx_word_valid(rx_word_valid), .rx_word(rx_word),
        .tx_word(tx_word), .regs_flat(regs_flat), .start(start), .busy(busy),
        .done(done), .result(result), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    bit chk_en = 0;

    logic [31:0] m_regs [NREGS];
    bit          m_active, m_rvalid, m_eop, m_eaddr, m_ebusy;
    logic [7:0]  m_cnt;
    logic [63:0] exp_tx;
    bit          exp_start;

    function automatic logic [7:0] m_status();
        return {3'b000, m_ebusy, m_eaddr, m_eop, m_rvalid, m_active};
    endfunction

    function automatic logic [NREGS*32-1:0] exp_flat();
        logic [NREGS*32-1:0] f;
        for (int i = 0; i < NREGS; i++) f[i*32 +: 32] = m_regs[i];
        return f;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NREGS; i++) m_regs[i] = 32'd0;
        m_active = 0; m_rvalid = 0; m_eop = 0; m_eaddr = 0; m_ebusy = 0;
        m_cnt = 8'd0; exp_tx = 64'd0; exp_start = 0;
    endtask

    task automatic check64(input string nm, input logic [63:0] act, input logic [63:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %016h expected %016h", nm, act, expv);
        end
    endtask

    task automatic check_regs(input string nm, input logic [NREGS*32-1:0] act,
                              input logic [NREGS*32-1:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, expv);
        end
    endtask

    // Command semantics: engine completion applies first, then the command.
    task automatic model_exec(input logic [63:0] w, input bit dn, input logic [31:0] res,
                              input bit bsy, output logic [63:0] rsp, output bit pulse);
        logic [7:0]  op, a;
        logic [31:0] d, rd;
        bit          ok;
        op = w[63:56]; a = w[55:48]; d = w[31:0]; rd = 32'd0; pulse = 0;
        ok = (int'(a) < NREGS);
        if (dn) begin
            m_regs[NREGS-1] = res; m_active = 0; m_rvalid = 1;
        end
        case (op)
            8'h01: if (ok) begin
                       if (!(dn && int'(a) == NREGS-1)) m_regs[int'(a)] = d;
                       rd = d;
                   end else m_eaddr = 1;
            8'h02: if (ok) rd = m_regs[int'(a)]; else m_eaddr = 1;
            8'h03: if (bsy || m_active) m_ebusy = 1;
                   else begin pulse = 1; m_active = 1; m_rvalid = 0; end
            8'h04: rd = m_regs[NREGS-1];
            8'h05: begin m_eop = 0; m_eaddr = 0; m_ebusy = 0; end
            default: m_eop = 1;
        endcase
        m_cnt = m_cnt + 8'd1;
        rsp = {op, a, m_status(), m_cnt, rd};
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check64("tx_word", tx_word, exp_tx);
            check_regs("regs_flat", regs_flat, exp_flat());
            check64("start", 64'(start), 64'(exp_start));
            check64("err", 64'(err), 64'(m_eop | m_eaddr | m_ebusy));
        end
    end

    task automatic send(input logic [63:0] w, input bit dn = 0, input logic [31:0] res = 0);
        logic [63:0] rsp;
        bit          p;
        @(posedge clk); #1 rx_word = w; rx_word_valid = 1;
        @(posedge clk); #1 if (dn) begin done = 1; result = res; end
        @(posedge clk); #1 done = 0;
        model_exec(w, dn, res, busy, rsp, p);
        exp_tx = rsp; exp_start = p;
        @(posedge clk); #1 exp_start = 0; rx_word_valid = 0;
    endtask

    task automatic pulse_done(input logic [31:0] res);
        @(posedge clk); #1 done = 1; result = res;
        @(posedge clk); #1 done = 0;
        m_regs[NREGS-1] = res; m_active = 0; m_rvalid = 1;
    endtask

    task automatic do_reset();
        chk_en = 0; resetn = 0;
        repeat (2) @(posedge clk);
        #1 resetn = 1;
        model_reset();
        chk_en = 1;
    endtask

    initial begin
        resetn = 0; rx_word_valid = 0; rx_word = '0; busy = 0; done = 0; result = '0;
        model_reset();
        do_reset();
        check64("rst_tx", tx_word, 64'd0);
        check64("rst_err", 64'(err), 64'd0);
        check_regs("rst_regs", regs_flat, '0);

        send(64'h0103_0000_DEADBEEF);
        check64("wr_tx", tx_word, 64'h0103_0001_DEADBEEF);
        check64("wr_reg3", 64'(regs_flat[127:96]), 64'h0000_0000_DEADBEEF);
        send(64'h0203_0000_0000_0000);
        check64("rd_tx", tx_word, 64'h0203_0002_DEADBEEF);
        send(64'h0209_0000_0000_0000);
        check64("rd_bad_tx", tx_word, 64'h0209_0803_0000_0000);
        check64("rd_bad_err", 64'(err), 64'd1);
        send(64'h0500_0000_0000_0000);
        check64("clr_tx", tx_word, 64'h0500_0004_0000_0000);

        send(64'h0300_0000_0000_0000);
        check64("start_tx", tx_word, 64'h0300_0105_0000_0000);
        send(64'h0300_0000_0000_0000);
        check64("start2_tx", tx_word, 64'h0300_1106_0000_0000);
        pulse_done(32'h1234_5678);
        send(64'h0400_0000_0000_0000);
        check64("status_tx", tx_word, 64'h0400_1207_1234_5678);
        send(64'h0500_0000_0000_0000);
        send(64'h7F00_0000_0000_0000);
        check64("badop_tx", tx_word, 64'h7F00_0609_0000_0000);
        send(64'h0500_0000_0000_0000);

        send(64'h0107_0000_AAAA_AAAA, 1, 32'h0000_0055);
        check64("wr7_done_tx", tx_word, 64'h0107_020B_AAAA_AAAA);
        check64("wr7_done_reg", 64'(regs_flat[255:224]), 64'h55);
        send(64'h0300_0000_0000_0000);
        check64("start3_tx", tx_word, 64'h0300_010C_0000_0000);
        send(64'h0300_0000_0000_0000, 1, 32'h0000_0099);
        check64("start_done_tx", tx_word, 64'h0300_010D_0000_0000);
        pulse_done(32'h0000_0077);
        busy = 1;
        send(64'h0300_0000_0000_0000);
        check64("start_busy_tx", tx_word, 64'h0300_120E_0000_0000);
        busy = 0;

        // Level held high through reset release must not execute.
        chk_en = 0;
        rx_word = 64'h0100_0000_0000_0055; rx_word_valid = 1; resetn = 0;
        repeat (2) @(posedge clk);
        #1 resetn = 1; model_reset(); chk_en = 1;
        repeat (4) @(posedge clk);
        #1 rx_word_valid = 0;
        check_regs("hold_valid_regs", regs_flat, '0);
        check64("hold_valid_tx", tx_word, 64'd0);

        // Reset asserted while a START is in EXEC.
        send(64'h0101_0000_0000_0011);
        @(posedge clk); #1 rx_word = 64'h0300_0000_0000_0000; rx_word_valid = 1;
        @(posedge clk); #1 chk_en = 0; resetn = 0;
        @(posedge clk); #1
        check64("rst_exec_tx", tx_word, 64'd0);
        check64("rst_exec_start", 64'(start), 64'd0);
        @(posedge clk); #1
        check64("rst_exec_start2", 64'(start), 64'd0);
        rx_word_valid = 0; resetn = 1; model_reset(); chk_en = 1;

        for (int i = 0; i < 256; i++) send(64'h0500_0000_0000_0000);
        check64("cnt_wrap_tx", tx_word, 64'h0500_0000_0000_0000);

        repeat (2) @(posedge clk);
        #1 chk_en = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
